itype_instr_sequencer: RTL and testbench

// Feeds the sodor5 core's imem response port with constrained-random RV32I I-type
// ALU instructions (opcode 7'b0010011) from an internal 32-bit LFSR.

---
 rtl/sodor_tb_pkg.sv | 34 +++
 rtl/lfsr32_galois.sv | 34 +++
 rtl/itype_instr_sequencer.sv | 139 +++++++++++++
 tb/tb_itype_instr_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_tb_pkg.sv
// Shared constants and types for the I-type instruction sequencer.
package sodor_tb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [6:0]      OPC_OP_IMM    = 7'b0010011;
    localparam logic [2:0]      F3_SLLI       = 3'b001;
    localparam logic [2:0]      F3_SRXI       = 3'b101;
    localparam logic [11:0]     IMM_MASK_SLLI = 12'h01F;
    localparam logic [11:0]     IMM_MASK_SRXI = 12'h41F;
    localparam logic [XLEN-1:0] INSTR_NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] LFSR_TAPS     = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Immediate mask that keeps shift-immediate encodings legal.
    function automatic logic [11:0] imm_mask(input logic [2:0] f3);
        logic [11:0] m;
        m = 12'hFFF;
        if (f3 == F3_SLLI) begin
            m = IMM_MASK_SLLI;
        end else if (f3 == F3_SRXI) begin
            m = IMM_MASK_SRXI;
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR; holds unless advance is asserted.
module lfsr32_galois
    import sodor_tb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] r_value;
    logic [31:0] w_next;

    // One Galois step: shift right, fold the taps in when a one falls out.
    always_comb begin
        w_next = {1'b0, r_value[31:1]};
        if (r_value[0]) begin
            w_next = w_next ^ LFSR_TAPS;
        end
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= seed;
        end else if (advance) begin
            r_value <= w_next;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/itype_instr_sequencer.sv
// Streams random RV32I OP-IMM instructions, then a NOP drain burst, to a core imem port.
module itype_instr_sequencer
    import sodor_tb_pkg::*;
#(
    parameter int unsigned NUM_INSTR  = 100,
    parameter int unsigned DRAIN_NOPS = 5,
    parameter logic [31:0] SEED       = 32'h0000_02CC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        imem_req_valid,
    output logic        imem_resp_valid,
    output logic [31:0] imem_resp_bits_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] issued_cnt
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic             r_start_q;
    logic             r_valid;
    logic [31:0]      r_data;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_drain_cnt;

    logic             w_go;
    logic             w_advance;
    logic [31:0]      w_lfsr;
    logic [11:0]      w_imm;
    logic [31:0]      w_run_word;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_drain_inc;
    logic             w_valid_nxt;
    logic [31:0]      w_data_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_drain_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    lfsr32_galois u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (SEED_EFF),
        .advance (w_advance),
        .value   (w_lfsr)
    );

    assign w_go        = start & ~r_start_q;
    assign w_cnt_inc   = r_issued_cnt + CNT_W'(1);
    assign w_drain_inc = r_drain_cnt + CNT_W'(1);

    // Format the current LFSR value as an OP-IMM word with a legal shift immediate.
    always_comb begin
        w_imm      = w_lfsr[31:20] & imm_mask(w_lfsr[14:12]);
        w_run_word = {w_imm, 20'h0_0000} | (w_lfsr & 32'h000F_FF80) | 32'(OPC_OP_IMM);
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_issued_cnt;
        w_drain_nxt = r_drain_cnt;
        w_advance   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_go) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_drain_nxt = '0;
                end
            end
            RUN: begin
                if (imem_req_valid) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_run_word;
                    w_cnt_nxt   = w_cnt_inc;
                    w_advance   = 1'b1;
                    if (w_cnt_inc == CNT_W'(NUM_INSTR)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (imem_req_valid) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = INSTR_NOP;
                    w_drain_nxt = w_drain_inc;
                    if (w_drain_inc == CNT_W'(DRAIN_NOPS)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_start_q    <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= INSTR_NOP;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_issued_cnt <= '0;
            r_drain_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_q    <= start;
            r_valid      <= w_valid_nxt;
            r_data       <= w_data_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_issued_cnt <= w_cnt_nxt;
            r_drain_cnt  <= w_drain_nxt;
        end
    end

    assign imem_resp_valid     = r_valid;
    assign imem_resp_bits_data = r_data;
    assign busy                = r_busy;
    assign done                = r_done;
    assign issued_cnt          = r_issued_cnt;

endmodule

// File: tb/tb_itype_instr_sequencer.sv
// Directed, table-driven bench for itype_instr_sequencer plus a long constrained-random run.
module tb_itype_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        req;
    logic        valid;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [15:0] cnt;

    logic        start_b;
    logic        req_b;
    logic        valid_b;
    logic [31:0] data_b;
    logic        busy_b;
    logic        done_b;
    logic [15:0] cnt_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    itype_instr_sequencer #(
        .NUM_INSTR  (4),
        .DRAIN_NOPS (5),
        .SEED       (32'hFFF0_D000)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .imem_req_valid      (req),
        .imem_resp_valid     (valid),
        .imem_resp_bits_data (data),
        .busy                (busy),
        .done                (done),
        .issued_cnt          (cnt)
    );

    itype_instr_sequencer #(
        .NUM_INSTR  (10000),
        .DRAIN_NOPS (5),
        .SEED       (32'h0000_02CC)
    ) dut_big (
        .clk                 (clk),
        .reset               (reset),
        .start               (start_b),
        .imem_req_valid      (req_b),
        .imem_resp_valid     (valid_b),
        .imem_resp_bits_data (data_b),
        .busy                (busy_b),
        .done                (done_b),
        .issued_cnt          (cnt_b)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic        rq;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] ec;
        logic        eb;
        logic        edn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic st, input logic rq, input logic ev,
                       input logic [31:0] ed, input logic [15:0] ec, input logic eb,
                       input logic edn);
        vec_t v;
        v.rst = rst; v.st = st; v.rq = rq; v.ev = ev;
        v.ed = ed; v.ec = ec; v.eb = eb; v.edn = edn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] v);
        logic [11:0] imm;
        logic [2:0]  f3;
        imm = v[31:20];
        f3  = v[14:12];
        if (f3 == 3'd1) imm = imm & 12'h01F;
        if (f3 == 3'd5) imm = imm & 12'h41F;
        return {imm, v[19:15], f3, v[11:7], 7'h13};
    endfunction

    initial begin
        int          idx;
        logic [31:0] m_lfsr;
        int          n_words;
        int          n_model_bad;
        int          n_mask_bad;
        int          n_sll;
        int          n_srx;
        int          n_nop;
        logic [6:0]  hi;

        reset = 1'b1; start = 1'b0; req = 1'b1;
        start_b = 1'b0; req_b = 1'b0;

        // reset state
        for (int k = 0; k < 3; k++) add(1, 0, 1, 0, 32'h13, 0, 0, 0);
        add(0, 0, 1, 0, 32'h13, 0, 0, 0);
        // run 1: four random words, five NOPs, then DONE
        add(0, 1, 1, 0, 32'h13,        0, 1, 0);
        add(0, 0, 1, 1, 32'h41F0_D013, 1, 1, 0);
        add(0, 0, 1, 1, 32'h7FF8_6813, 2, 1, 0);
        add(0, 0, 1, 1, 32'h3FFC_3413, 3, 1, 0);
        add(0, 0, 1, 1, 32'h01FE_1A13, 4, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 1, 32'h13, 4, 1, 0);
        add(0, 0, 1, 1, 32'h13, 4, 0, 1);
        add(0, 0, 1, 0, 32'h13, 4, 0, 1);
        add(0, 0, 0, 0, 32'h13, 4, 0, 1);
        // run 2: gapped requests, LFSR continues from run 1
        add(0, 1, 0, 0, 32'h13,        0, 1, 0);
        add(0, 0, 1, 1, 32'h0FFF_0D13, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0FFF_0D13, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0FFF_0D13, 1, 1, 0);
        add(0, 0, 1, 1, 32'h07FF_8693, 2, 1, 0);
        add(0, 0, 0, 0, 32'h07FF_8693, 2, 1, 0);
        add(0, 0, 1, 1, 32'h03FF_C313, 3, 1, 0);
        add(0, 0, 0, 0, 32'h03FF_C313, 3, 1, 0);
        add(0, 0, 1, 1, 32'h01FF_E193, 4, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 1, 32'h13, 4, 1, 0);
        add(0, 0, 1, 1, 32'h13, 4, 0, 1);
        // run 3: two issues, then reset mid-run and restart from the seed
        add(0, 1, 1, 0, 32'h13,        0, 1, 0);
        add(0, 0, 1, 1, 32'h00FF_F093, 1, 1, 0);
        add(0, 0, 1, 1, 32'h007F_F813, 2, 1, 0);
        add(1, 0, 1, 0, 32'h13,        0, 0, 0);
        add(1, 0, 1, 0, 32'h13,        0, 0, 0);
        add(0, 0, 1, 0, 32'h13,        0, 0, 0);
        add(0, 1, 1, 0, 32'h13,        0, 1, 0);
        add(0, 0, 1, 1, 32'h41F0_D013, 1, 1, 0);

        idx = 0;
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            start = vecs[i].st;
            req   = vecs[i].rq;
            tick();
            chk($sformatf("v%0d.valid", i), 32'(valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d.data",  i), data,       vecs[i].ed);
            chk($sformatf("v%0d.cnt",   i), 32'(cnt),   32'(vecs[i].ec));
            chk($sformatf("v%0d.busy",  i), 32'(busy),  32'(vecs[i].eb));
            chk($sformatf("v%0d.done",  i), 32'(done),  32'(vecs[i].edn));
            idx++;
        end

        // start edge while in RUN is ignored
        start = 1'b1; req = 1'b1;
        tick();
        chk("run_go_ignored.cnt",  32'(cnt), 32'd2);
        chk("run_go_ignored.data", data, 32'h7FF8_6813);
        for (int k = 0; k < 40 && done !== 1'b1; k++) tick();
        chk("run4.done", 32'(done), 32'd1);
        chk("run4.cnt",  32'(cnt),  32'd4);
        // start held high in DONE must not rerun
        for (int k = 0; k < 3; k++) tick();
        chk("held_start.done",  32'(done),  32'd1);
        chk("held_start.busy",  32'(busy),  32'd0);
        chk("held_start.valid", 32'(valid), 32'd0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("rerun.busy", 32'(busy), 32'd1);
        chk("rerun.done", 32'(done), 32'd0);
        chk("rerun.cnt",  32'(cnt),  32'd0);
        start = 1'b0; req = 1'b0;

        // long run: every word against an independent LFSR model and the shift-imm rules
        m_lfsr = 32'h0000_02CC;
        n_words = 0; n_model_bad = 0; n_mask_bad = 0; n_sll = 0; n_srx = 0; n_nop = 0;
        req_b = 1'b1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 11000 && done_b !== 1'b1; k++) begin
            tick();
            if (valid_b === 1'b1) begin
                if (n_words < 10000) begin
                    if (data_b !== model_word(m_lfsr)) n_model_bad++;
                    m_lfsr = model_next(m_lfsr);
                    hi = data_b[31:25];
                    if (data_b[6:0] !== 7'h13) n_mask_bad++;
                    if (data_b[14:12] == 3'd1) begin
                        n_sll++;
                        if (hi != 7'h00) n_mask_bad++;
                    end
                    if (data_b[14:12] == 3'd5) begin
                        n_srx++;
                        if (hi != 7'h00 && hi != 7'h20) n_mask_bad++;
                    end
                    n_words++;
                end else begin
                    n_nop++;
                    if (data_b !== 32'h13) n_model_bad++;
                end
            end
        end
        chk("big.done",       32'(done_b),      32'd1);
        chk("big.words",      32'(n_words),     32'd10000);
        chk("big.nops",       32'(n_nop),       32'd5);
        chk("big.cnt",        32'(cnt_b),       32'd10000);
        chk("big.model_bad",  32'(n_model_bad), 32'd0);
        chk("big.mask_bad",   32'(n_mask_bad),  32'd0);
        chk("big.sll_seen",   32'(n_sll > 0),   32'd1);
        chk("big.srx_seen",   32'(n_srx > 0),   32'd1);
        tick();
        chk("big.valid_after", 32'(valid_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
